// File: rtl/sysid_pkg.sv
// Shared types and constants for the system ID boot checker.
package sysid_pkg;

    // Checker sequencing states: read the ID word, then the timestamp word.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ID_REQ  = 3'd1,
        ST_ID_WAIT = 3'd2,
        ST_TS_REQ  = 3'd3,
        ST_TS_WAIT = 3'd4,
        ST_DONE    = 3'd5
    } sysidState_e;

    // Word addresses inside the sysid slave.
    localparam logic SYSID_ADDR_ID = 1'b0;
    localparam logic SYSID_ADDR_TS = 1'b1;

endpackage

// File: rtl/sysid_rd_timer.sv
// Read timeout counter plus retry counter used by the boot checker.
// The timeout counter restarts on load, counts while enabled and saturates
// at its last value; expire is raised while enabled on that last value.
module sysid_rd_timer #(
    parameter int TIMEOUT_CYCLES = 256,
    parameter int MAX_RETRIES    = 2
) (
    input  logic clock,
    input  logic reset_n,
    input  logic load_i,
    input  logic enable_i,
    input  logic retryClr_i,
    input  logic retryInc_i,
    output logic expire_o,
    output logic retriesLeft_o
);

    localparam logic [15:0] COUNT_LAST = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [2:0]  RETRY_MAX  = 3'(MAX_RETRIES);

    logic [15:0] count_q, count_d;
    logic [2:0]  retry_q, retry_d;

    // Next-state for the timeout and retry counters; load and clear take priority.
    always_comb begin
        count_d = count_q;
        retry_d = retry_q;
        if (load_i) begin
            count_d = 16'd0;
        end else if (enable_i && (count_q != COUNT_LAST)) begin
            count_d = count_q + 16'd1;
        end
        if (retryClr_i) begin
            retry_d = 3'd0;
        end else if (retryInc_i && (retry_q != RETRY_MAX)) begin
            retry_d = retry_q + 3'd1;
        end
    end

    // Counter registers, cleared asynchronously by reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= 16'd0;
            retry_q <= 3'd0;
        end else begin
            count_q <= count_d;
            retry_q <= retry_d;
        end
    end

    assign expire_o      = enable_i && (count_q == COUNT_LAST);
    assign retriesLeft_o = (retry_q < RETRY_MAX);

endmodule

// File: rtl/sysid_boot_checker.sv
// Avalon-MM read master that fetches the sysid ID and timestamp words after
// reset (or on start), compares them with build-time values and publishes
// the captured words together with pass/fail status flags.
module sysid_boot_checker
    import sysid_pkg::*;
#(
    parameter logic [31:0] EXP_ID         = 32'h0000_0000,
    parameter logic [31:0] EXP_TIMESTAMP  = 32'd1530973843,
    parameter bit          CHECK_TS       = 1'b1,
    parameter int          TIMEOUT_CYCLES = 256,
    parameter int          MAX_RETRIES    = 2
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    input  logic        avm_readdatavalid,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic        id_mismatch,
    output logic        ts_mismatch,
    output logic        timeout_err,
    output logic [31:0] id_value,
    output logic [31:0] ts_value
);

    sysidState_e state_q, state_d;
    logic        autoStart_q;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        pass_q, pass_d;
    logic        idMismatch_q, idMismatch_d;
    logic        tsMismatch_q, tsMismatch_d;
    logic        timeoutErr_q, timeoutErr_d;
    logic [31:0] idValue_q, idValue_d;
    logic [31:0] tsValue_q, tsValue_d;

    logic readAccepted;
    logic tsPhase;
    logic timerLoad;
    logic timerEnable;
    logic retryClr;
    logic retryInc;
    logic timerExpire;
    logic retriesLeft;
    logic timeoutHit;
    logic tsMismatchNow;

    assign avm_read     = (state_q == ST_ID_REQ) || (state_q == ST_TS_REQ);
    assign avm_address  = (state_q == ST_TS_REQ) ? SYSID_ADDR_TS : SYSID_ADDR_ID;
    assign readAccepted = avm_read && !avm_waitrequest;
    assign tsPhase      = (state_q == ST_TS_REQ) || (state_q == ST_TS_WAIT);
    assign timerEnable  = avm_read || (state_q == ST_ID_WAIT) || (state_q == ST_TS_WAIT);
    assign tsMismatchNow = (avm_readdata != EXP_TIMESTAMP);

    sysid_rd_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .MAX_RETRIES   (MAX_RETRIES)
    ) u_timer (
        .clock        (clock),
        .reset_n      (reset_n),
        .load_i       (timerLoad),
        .enable_i     (timerEnable),
        .retryClr_i   (retryClr),
        .retryInc_i   (retryInc),
        .expire_o     (timerExpire),
        .retriesLeft_o(retriesLeft)
    );

    // Sequencing, capture and compare; a timeout either retries the same request or aborts to DONE.
    always_comb begin
        state_d      = state_q;
        busy_d       = busy_q;
        done_d       = done_q;
        pass_d       = pass_q;
        idMismatch_d = idMismatch_q;
        tsMismatch_d = tsMismatch_q;
        timeoutErr_d = timeoutErr_q;
        idValue_d    = idValue_q;
        tsValue_d    = tsValue_q;
        timerLoad    = 1'b0;
        retryClr     = 1'b0;
        retryInc     = 1'b0;
        timeoutHit   = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start || autoStart_q) begin
                    state_d      = ST_ID_REQ;
                    busy_d       = 1'b1;
                    done_d       = 1'b0;
                    pass_d       = 1'b0;
                    idMismatch_d = 1'b0;
                    tsMismatch_d = 1'b0;
                    timeoutErr_d = 1'b0;
                    timerLoad    = 1'b1;
                    retryClr     = 1'b1;
                end
            end
            ST_ID_REQ: begin
                if (readAccepted) begin
                    state_d = ST_ID_WAIT;
                end else if (timerExpire) begin
                    timeoutHit = 1'b1;
                end
            end
            ST_ID_WAIT: begin
                if (avm_readdatavalid) begin
                    idValue_d = avm_readdata;
                    retryClr  = 1'b1;
                    timerLoad = 1'b1;
                    state_d   = ST_TS_REQ;
                end else if (timerExpire) begin
                    timeoutHit = 1'b1;
                end
            end
            ST_TS_REQ: begin
                if (readAccepted) begin
                    state_d = ST_TS_WAIT;
                end else if (timerExpire) begin
                    timeoutHit = 1'b1;
                end
            end
            ST_TS_WAIT: begin
                if (avm_readdatavalid) begin
                    tsValue_d    = avm_readdata;
                    retryClr     = 1'b1;
                    state_d      = ST_DONE;
                    busy_d       = 1'b0;
                    done_d       = 1'b1;
                    idMismatch_d = (idValue_q != EXP_ID);
                    tsMismatch_d = tsMismatchNow;
                    pass_d       = (idValue_q == EXP_ID) && !(CHECK_TS && tsMismatchNow);
                end else if (timerExpire) begin
                    timeoutHit = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (timeoutHit) begin
            if (retriesLeft) begin
                retryInc  = 1'b1;
                timerLoad = 1'b1;
                state_d   = tsPhase ? ST_TS_REQ : ST_ID_REQ;
            end else begin
                state_d      = ST_DONE;
                busy_d       = 1'b0;
                done_d       = 1'b1;
                pass_d       = 1'b0;
                timeoutErr_d = 1'b1;
                idMismatch_d = tsPhase && (idValue_q != EXP_ID);
                tsMismatch_d = 1'b0;
            end
        end
    end

    // State, status and capture registers; reset clears everything and arms the auto-start.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            autoStart_q  <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            idMismatch_q <= 1'b0;
            tsMismatch_q <= 1'b0;
            timeoutErr_q <= 1'b0;
            idValue_q    <= 32'd0;
            tsValue_q    <= 32'd0;
        end else begin
            state_q      <= state_d;
            autoStart_q  <= 1'b0;
            busy_q       <= busy_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
            idMismatch_q <= idMismatch_d;
            tsMismatch_q <= tsMismatch_d;
            timeoutErr_q <= timeoutErr_d;
            idValue_q    <= idValue_d;
            tsValue_q    <= tsValue_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign pass        = pass_q;
    assign id_mismatch = idMismatch_q;
    assign ts_mismatch = tsMismatch_q;
    assign timeout_err = timeoutErr_q;
    assign id_value    = idValue_q;
    assign ts_value    = tsValue_q;

endmodule
